// File: rtl/td4_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// td4_sequencer_pkg
// Shared definitions for the TD4 fetch/execute sequencer: bus widths, the
// bit positions of the decoder load vector, the controller state encoding and
// a small PC helper.
// ----------------------------------------------------------------------------
package td4_sequencer_pkg;

    localparam int INSTR_W = 8;   // instruction word width
    localparam int ADDR_W  = 4;   // program address width
    localparam int LOAD_W  = 4;   // load vector width {PC,OUT,B,A}

    // Bit positions inside the decoder load vector / write strobes
    localparam int LD_A   = 0;
    localparam int LD_B   = 1;
    localparam int LD_OUT = 2;
    localparam int LD_PC  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } seq_state_e;

    // Sequential successor of a program address; wraps F -> 0 naturally.
    function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] pc);
        return pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/td4_sequencer_if.sv
// ----------------------------------------------------------------------------
// td4_sequencer_if
// Program ROM fetch bus between the sequencer (master) and the ROM (slave).
//   rom_req   master -> slave  fetch request, held until acknowledged
//   rom_addr  master -> slave  fetch address (program counter)
//   rom_ack   slave  -> master rom_data valid this cycle
//   rom_data  slave  -> master instruction word
// ----------------------------------------------------------------------------
interface td4_sequencer_if;
    import td4_sequencer_pkg::*;

    logic               rom_req;
    logic [ADDR_W-1:0]  rom_addr;
    logic               rom_ack;
    logic [INSTR_W-1:0] rom_data;

    modport master (
        output rom_req,
        output rom_addr,
        input  rom_ack,
        input  rom_data
    );

    modport slave (
        input  rom_req,
        input  rom_addr,
        output rom_ack,
        output rom_data
    );

endinterface

// File: rtl/td4_sequencer.sv
// ----------------------------------------------------------------------------
// td4_sequencer
// Multi-cycle fetch/execute controller for the TD4 4-bit CPU. Owns the program
// counter, the instruction register and the carry flag. Fetches one
// instruction over the ROM req/ack bus, then spends exactly one EXEC cycle in
// which the decoder's load vector is passed out as write strobes. Supports
// free-running, single-step (rising edge of step_i) and a sticky halt on
// jump-to-self or on a ROM timeout.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_ni       synchronous reset, active low
//   run_i        level, 1 = fetch/execute continuously
//   step_i       rising edge in IDLE executes one instruction
//   rom          td4_sequencer_if.master fetch bus
//   command_o    instruction register, to decoder
//   cflag_o      carry flag register, to decoder
//   dec_load_i   decoder load vector {PC,OUT,B,A}
//   alu_carry_i  adder carry for the current instruction
//   pc_in_i      ALU result, jump target when dec_load_i[LD_PC]
//   load_en_o    one-cycle write strobes {PC,OUT,B,A}
//   pc_o         program counter
//   halted_o     sticky halt flag
//   fault_o      sticky ROM timeout flag
// ----------------------------------------------------------------------------
module td4_sequencer
    import td4_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 15   // FETCH cycles without ack before fault (1..255)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               run_i,
    input  logic               step_i,
    td4_sequencer_if.master    rom,
    output logic [INSTR_W-1:0] command_o,
    output logic               cflag_o,
    input  logic [LOAD_W-1:0]  dec_load_i,
    input  logic               alu_carry_i,
    input  logic [ADDR_W-1:0]  pc_in_i,
    output logic [LOAD_W-1:0]  load_en_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic               halted_o,
    output logic               fault_o
);

    localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

    seq_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               cflag_q, cflag_d;
    logic               halted_q, halted_d;
    logic               fault_q, fault_d;
    logic [7:0]         tmo_q, tmo_d;
    logic               step_q;

    logic               step_rise;
    logic               jump_self;
    logic               fetch_expire;
    logic               rom_req;
    logic [LOAD_W-1:0]  load_en;

    // step_q is the previous sample of step_i; only a 0->1 transition counts.
    assign step_rise    = step_i & ~step_q;
    // A jump whose target is the current address can never make progress.
    assign jump_self    = dec_load_i[LD_PC] && (pc_in_i == pc_q);
    // The cycle that would bring the miss count up to TIMEOUT is the last one.
    assign fetch_expire = ((tmo_q + 8'd1) == TMO_LIM);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                // RUN and a STEP edge together still start a single fetch.
                if (run_i || step_rise) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (rom.rom_ack) begin
                    state_d = ST_EXEC;
                end else if (fetch_expire) begin
                    state_d = ST_HALT;
                end
            end
            ST_EXEC: begin
                // RUN is looked at only here, so dropping it mid-fetch still
                // lets the current instruction finish.
                if (jump_self) begin
                    state_d = ST_HALT;
                end else if (run_i) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        rom_req = 1'b0;
        load_en = '0;
        unique case (state_q)
            ST_FETCH: rom_req = 1'b1;
            ST_EXEC:  load_en = dec_load_i;
            default: begin
                rom_req = 1'b0;
                load_en = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // PC / IR / flags next-state
    // ------------------------------------------------------------------
    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        cflag_d  = cflag_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        tmo_d    = tmo_q;
        unique case (state_q)
            ST_FETCH: begin
                if (rom.rom_ack) begin
                    ir_d  = rom.rom_data;
                    tmo_d = 8'd0;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                    if (fetch_expire) begin
                        fault_d  = 1'b1;
                        halted_d = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                // Carry is captured every instruction, so a JNC always sees
                // the carry of the instruction before it.
                cflag_d = alu_carry_i;
                if (jump_self) begin
                    halted_d = 1'b1;
                end else if (dec_load_i[LD_PC]) begin
                    pc_d = pc_in_i;
                end else begin
                    pc_d = pc_incr(pc_q);
                end
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // PC / IR / flags registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q     <= '0;
            ir_q     <= '0;
            cflag_q  <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            tmo_q    <= 8'd0;
            step_q   <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            cflag_q  <= cflag_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
            tmo_q    <= tmo_d;
            step_q   <= step_i;
        end
    end

    assign rom.rom_req  = rom_req;
    assign rom.rom_addr = pc_q;
    assign load_en_o    = load_en;
    assign command_o    = ir_q;
    assign cflag_o      = cflag_q;
    assign pc_o         = pc_q;
    assign halted_o     = halted_q;
    assign fault_o      = fault_q;

endmodule

// File: tb/tb_td4_sequencer.sv
// ----------------------------------------------------------------------------
// tb_td4_sequencer
// Instruction-level bench for td4_sequencer. The bench plays ROM, decoder and
// ALU; a reference model tracks PC, carry flag and halt per instruction.
// ----------------------------------------------------------------------------
module tb_td4_sequencer;
    import td4_sequencer_pkg::*;

    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       step;
    logic [7:0] command;
    logic       cflag;
    logic [3:0] dec_load;
    logic       alu_carry;
    logic [3:0] pc_in;
    logic [3:0] load_en;
    logic [3:0] pc;
    logic       halted;
    logic       fault;

    td4_sequencer_if rom_if();

    td4_sequencer #(.TIMEOUT(TMO)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .run_i       (run),
        .step_i      (step),
        .rom         (rom_if),
        .command_o   (command),
        .cflag_o     (cflag),
        .dec_load_i  (dec_load),
        .alu_carry_i (alu_carry),
        .pc_in_i     (pc_in),
        .load_en_o   (load_en),
        .pc_o        (pc),
        .halted_o    (halted),
        .fault_o     (fault)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    logic [3:0] m_pc;
    logic       m_cf;
    logic       m_halt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        dec_load        = 4'($urandom);
        alu_carry       = 1'($urandom);
        pc_in           = 4'($urandom);
        rom_if.rom_data = 8'($urandom);
    endtask

    task automatic reset_dut();
        rst_n          = 1'b0;
        run            = 1'($urandom);
        step           = 1'b0;
        rom_if.rom_ack = 1'($urandom);
        noise();
        cyc();
        #1;
        chk("rst_pc", pc, 0);
        chk("rst_cmd", command, 0);
        chk("rst_cflag", cflag, 0);
        chk("rst_req", rom_if.rom_req, 0);
        chk("rst_load", load_en, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fault", fault, 0);
        rst_n = 1'b1;
        run   = 1'b0;
        cyc();
        m_pc   = 4'd0;
        m_cf   = 1'b0;
        m_halt = 1'b0;
    endtask

    // DUT idle on entry; leaves it in its first FETCH cycle.
    task automatic start_idle(input bit use_step, input int idle_n);
        for (int i = 0; i < idle_n; i++) begin
            run = 1'b0;
            step = 1'b0;
            rom_if.rom_ack = 1'($urandom);
            noise();
            #1;
            chk("idle_req", rom_if.rom_req, 0);
            chk("idle_load", load_en, 0);
            cyc();
        end
        if (use_step) begin
            step = 1'b1;
            run  = 1'($urandom_range(0, 3) == 0);
        end else begin
            run  = 1'b1;
            step = 1'b0;
        end
        rom_if.rom_ack = 1'b0;
        noise();
        #1;
        chk("start_req", rom_if.rom_req, 0);
        cyc();
    endtask

    // DUT in its first FETCH cycle on entry. Ack after wt wait cycles, then
    // one EXEC cycle driven with dl/carry/pcin and run = run_after.
    task automatic do_instr(input int wt, input logic [7:0] data, input logic [3:0] dl,
                            input logic carry, input logic [3:0] pcin,
                            input logic run_after, input bit hold_run);
        for (int k = 0; k <= wt; k++) begin
            noise();
            rom_if.rom_ack = (k == wt);
            if (k == wt) rom_if.rom_data = data;
            run  = hold_run ? 1'b1 : 1'($urandom);
            step = 1'($urandom);
            #1;
            chk("fetch_req", rom_if.rom_req, 1);
            chk("fetch_addr", rom_if.rom_addr, m_pc);
            chk("fetch_load", load_en, 0);
            chk("fetch_fault", fault, 0);
            cyc();
        end
        rom_if.rom_ack  = 1'($urandom);
        rom_if.rom_data = 8'($urandom);
        dec_load  = dl;
        alu_carry = carry;
        pc_in     = pcin;
        run       = run_after;
        step      = 1'($urandom);
        #1;
        chk("exec_cmd", command, data);
        chk("exec_load", load_en, dl);
        chk("exec_req", rom_if.rom_req, 0);
        chk("exec_cflag", cflag, m_cf);
        cyc();
        m_cf = carry;
        if (dl[3] && pcin == m_pc) m_halt = 1'b1;
        else m_pc = dl[3] ? pcin : m_pc + 4'd1;
        chk("post_pc", pc, m_pc);
        chk("post_cflag", cflag, m_cf);
        chk("post_halted", halted, m_halt);
    endtask

    task automatic halt_check();
        for (int i = 0; i < 4; i++) begin
            run = 1'($urandom);
            step = 1'($urandom);
            rom_if.rom_ack = 1'($urandom);
            noise();
            #1;
            chk("halt_req", rom_if.rom_req, 0);
            chk("halt_load", load_en, 0);
            chk("halt_flag", halted, 1);
            chk("halt_pc", pc, m_pc);
            cyc();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit active;
        logic [3:0] dl;
        logic ra;

        // ADD A,1 x16 free-running, zero-wait ROM: PC wraps back to 0
        reset_dut();
        start_idle(1'b0, 1);
        for (int i = 0; i < 16; i++)
            do_instr(0, 8'h01, 4'b0001, 1'b0, 4'($urandom), 1'b1, 1'b1);
        chk("wrap_pc", pc, 0);

        // delayed ack, RUN dropped at EXEC -> IDLE
        do_instr(3, 8'h01, 4'b0001, 1'b0, 4'($urandom), 1'b0, 1'b1);

        // carry then JNC not taken; non-carry op then JNC taken
        start_idle(1'b0, 1);
        do_instr(0, 8'h01, 4'b0001, 1'b1, 4'($urandom), 1'b1, 1'b1);
        chk("carry_set", cflag, 1);
        do_instr(0, 8'hE5, 4'b0000, 1'b0, 4'd5, 1'b1, 1'b1);
        do_instr(0, 8'h01, 4'b0001, 1'b0, 4'($urandom), 1'b1, 1'b1);
        do_instr(0, 8'hE5, 4'b1000, 1'b0, 4'd5, 1'b0, 1'b1);
        chk("jnc_taken", pc, 5);

        // three STEP pulses with RUN low
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            start_idle(1'b1, 2);
            do_instr($urandom_range(0, 3), 8'($urandom), 4'($urandom) & 4'b0111,
                     1'($urandom), 4'($urandom), 1'b0, 1'b0);
        end
        chk("step_pc", pc, 3);
        for (int i = 0; i < 3; i++) begin
            run = 1'b0;
            step = 1'b0;
            #1;
            chk("step_idle", rom_if.rom_req, 0);
            cyc();
        end

        // jump-to-self at address 7
        reset_dut();
        start_idle(1'b0, 1);
        for (int i = 0; i < 7; i++)
            do_instr(0, 8'h00, 4'b0000, 1'b0, 4'($urandom), 1'b1, 1'b1);
        do_instr(0, 8'hF7, 4'b1000, 1'b0, 4'd7, 1'b1, 1'b1);
        chk("self_pc", pc, 7);
        halt_check();

        // ROM timeout
        reset_dut();
        start_idle(1'b0, 1);
        for (int k = 0; k < TMO; k++) begin
            rom_if.rom_ack = 1'b0;
            run = 1'b1;
            noise();
            #1;
            chk("tmo_req", rom_if.rom_req, 1);
            chk("tmo_fault_early", fault, 0);
            cyc();
        end
        #1;
        chk("tmo_fault", fault, 1);
        chk("tmo_halted", halted, 1);
        m_halt = 1'b1;
        halt_check();

        // reset in the middle of a fetch
        reset_dut();
        start_idle(1'b0, 1);
        for (int k = 0; k < 2; k++) begin
            rom_if.rom_ack = 1'b0;
            run = 1'b1;
            noise();
            cyc();
        end
        reset_dut();

        // randomized instruction stream
        active = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (m_halt) begin
                halt_check();
                reset_dut();
                active = 1'b0;
            end
            if (!active) start_idle(1'($urandom), $urandom_range(1, 3));
            dl = 4'($urandom);
            ra = 1'($urandom_range(0, 3) != 0);
            do_instr($urandom_range(0, 4), 8'($urandom), dl, 1'($urandom),
                     4'($urandom), ra, 1'b0);
            active = ra && !m_halt;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
